vga_fb_reader: RTL and testbench



---
 rtl/vga_fb_reader.sv | 183 ++++++++++++++++++
 tb/tb_vga_fb_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
// vga_fb_reader
//   640x480@60 Hz VGA scan-out from a 50 MHz system clock. Reads a 1-bpp,
//   160x120 framebuffer (10 words per row, MSB leftmost) through the read-only
//   BRAM port B. Each framebuffer bit covers a 4x4 block of screen pixels.
//   Words are prefetched a few pixels ahead of the point where they are needed.
//   Optional feature macro: VGA_BORDER_EN. When it is defined, a one-pixel
//   FG_RGB frame is drawn around the visible area. Fetch timing is unchanged.
module vga_fb_reader #(
    parameter logic [15:0] FB_BASE = 16'h0C00,
    parameter logic [23:0] FG_RGB  = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB  = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] addr_b,
    input  logic [15:0] q_b,
    output logic        we_b,
    output logic        vga_clk,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    localparam logic [9:0] H_VISIBLE     = 10'd640;
    localparam logic [9:0] H_SYNC_START  = 10'd656;
    localparam logic [9:0] H_SYNC_END    = 10'd752;
    localparam logic [9:0] H_LAST        = 10'd799;
    localparam logic [9:0] V_VISIBLE     = 10'd480;
    localparam logic [9:0] V_SYNC_START  = 10'd490;
    localparam logic [9:0] V_SYNC_END    = 10'd492;
    localparam logic [9:0] V_LAST        = 10'd524;
    // Mid-line fetch/capture slots stop after word 9 has been requested (hcount 572/574).
    localparam logic [9:0] H_MID_LIMIT   = 10'd576;
    localparam logic [9:0] H_EOL_FETCH   = 10'd796;
    localparam logic [9:0] H_EOL_CAPTURE = 10'd798;

    logic        pix_en;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [15:0] next_word;
    logic [15:0] shreg;

    logic        line_vis;
    logic        h_vis;
    logic [9:0]  next_line;
    logic [15:0] cur_row;
    logic [15:0] nxt_row;
    logic [15:0] word_idx;
    logic [15:0] row_base;
    logic [15:0] next_row_base;
    logic [15:0] addr_mid;
    logic        fetch_mid;
    logic        fetch_eol;
    logic        capture;
    logic        load_word;
    logic        shift_bit;
    logic        pix_bit;
    logic        border;
    logic [23:0] pix_rgb;

    assign we_b       = 1'b0;
    assign vga_sync_n = 1'b0;
    assign vga_clk    = pix_en;

    // Decode the current raster position into fetch, capture, shift and colour decisions.
    always_comb begin
        line_vis      = vcount < V_VISIBLE;
        h_vis         = hcount < H_VISIBLE;
        next_line     = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        cur_row       = {6'd0, vcount} >> 2;
        nxt_row       = {6'd0, next_line} >> 2;
        word_idx      = {6'd0, hcount} >> 6;
        // row*10 as row*8 + row*2, 16-bit with natural wrap.
        row_base      = FB_BASE + (cur_row << 3) + (cur_row << 1);
        next_row_base = FB_BASE + (nxt_row << 3) + (nxt_row << 1);
        addr_mid      = row_base + word_idx + 16'd1;

        fetch_mid = line_vis && (hcount[5:0] == 6'd60) && (hcount < H_MID_LIMIT);
        // Word 0 of the coming line is only needed if that line is visible.
        fetch_eol = (hcount == H_EOL_FETCH) &&
                    ((vcount == V_LAST) || (vcount < (V_VISIBLE - 10'd1)));
        capture   = ((hcount[5:0] == 6'd62) && (hcount < H_MID_LIMIT)) ||
                    (hcount == H_EOL_CAPTURE);
        load_word = line_vis && h_vis && (hcount[5:0] == 6'd0);
        shift_bit = hcount[1:0] == 2'd3;

        // On a word boundary the freshly loaded word supplies the pixel,
        // so the first screen pixel of each word is its MSB.
        pix_bit = load_word ? next_word[15] : shreg[15];

`ifdef VGA_BORDER_EN
        border = line_vis && h_vis &&
                 ((hcount == 10'd0) || (hcount == (H_VISIBLE - 10'd1)) ||
                  (vcount == 10'd0) || (vcount == (V_VISIBLE - 10'd1)));
`else
        border = 1'b0;
`endif

        if (!(line_vis && h_vis)) begin
            pix_rgb = 24'd0;
        end else if (border || pix_bit) begin
            pix_rgb = FG_RGB;
        end else begin
            pix_rgb = BG_RGB;
        end
    end

    // Pixel tick: divide clk by two; everything else advances only when pix_en is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    // Raster counters, 800 ticks per line and 525 lines per frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hcount <= 10'd0;
            vcount <= 10'd0;
        end else if (pix_en) begin
            if (hcount == H_LAST) begin
                hcount <= 10'd0;
                vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount <= hcount + 10'd1;
            end
        end
    end

    // BRAM port B address issue and read-data capture; address holds between fetches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_b    <= FB_BASE;
            next_word <= 16'd0;
        end else if (pix_en) begin
            if (fetch_mid) begin
                addr_b <= addr_mid;
            end else if (fetch_eol) begin
                addr_b <= next_row_base;
            end
            if (capture) begin
                next_word <= q_b;
            end
        end
    end

    // Pixel shifter: load on word boundaries, otherwise advance one bit every 4 ticks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg <= 16'd0;
        end else if (pix_en) begin
            if (load_word) begin
                shreg <= next_word;
            end else if (shift_bit) begin
                shreg <= {shreg[14:0], 1'b0};
            end
        end
    end

    // Video outputs registered together so syncs, blank and colour stay aligned.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= 8'd0;
            vga_g       <= 8'd0;
            vga_b       <= 8'd0;
        end else if (pix_en) begin
            vga_hs      <= !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
            vga_vs      <= !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
            vga_blank_n <= line_vis && h_vis;
            {vga_r, vga_g, vga_b} <= pix_rgb;
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Testbench for vga_fb_reader: BRAM model on port B, behavioural raster/pixel
// reference, randomized framebuffer contents plus directed words.
// Honours VGA_BORDER_EN when the design is built with it.
`timescale 1ns/1ps
module tb_vga_fb_reader;

    localparam logic [15:0] FB_BASE = 16'h0C00;
    localparam logic [23:0] FG_RGB  = 24'hE0C040;
    localparam logic [23:0] BG_RGB  = 24'h102030;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr_b;
    logic [15:0] q_b;
    logic        we_b;
    logic        vga_clk;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vga_sync_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:65535];

    // reference model state
    int          mh, mv, cur_h, cur_v;
    bit          mpe, first_frame, cur_first, half_clk;
    logic [15:0] e_addr;
    logic [23:0] e_rgb;
    logic        e_hs, e_vs, e_blank;

    vga_fb_reader #(
        .FB_BASE (FB_BASE),
        .FG_RGB  (FG_RGB),
        .BG_RGB  (BG_RGB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr_b      (addr_b),
        .q_b         (q_b),
        .we_b        (we_b),
        .vga_clk     (vga_clk),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_sync_n  (vga_sync_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    always #10 clk = ~clk;

    // synchronous-read BRAM: data for an address appears one clk after it is presented
    always @(posedge clk) q_b <= mem[addr_b];

    initial begin
        #3ms;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Expected colour of screen pixel (h,v) straight from the framebuffer layout.
    function automatic logic [23:0] exp_rgb(int h, int v, bit first);
        logic [15:0] a;
        logic [15:0] w;
        if (h >= 640 || v >= 480) return 24'h0;
`ifdef VGA_BORDER_EN
        if (h == 0 || h == 639 || v == 0 || v == 479) return FG_RGB;
`endif
        if (first && v == 0 && h < 64) return BG_RGB;
        a = FB_BASE + 16'((v / 4) * 10 + h / 64);
        w = mem[a];
        return w[15 - (h / 4) % 16] ? FG_RGB : BG_RGB;
    endfunction

    // Advance to the negedge after the next pixel tick and compute expected outputs.
    task automatic tick();
        bit was;
        was = 1'b0;
        while (!was) begin
            @(posedge clk);
            was = mpe;
            mpe = ~mpe;
            @(negedge clk);
            if (!was) half_clk = vga_clk;
        end
        cur_h     = mh;
        cur_v     = mv;
        cur_first = first_frame;
        e_rgb     = exp_rgb(cur_h, cur_v, cur_first);
        e_hs      = !(cur_h >= 656 && cur_h < 752);
        e_vs      = !(cur_v >= 490 && cur_v < 492);
        e_blank   = (cur_h < 640 && cur_v < 480);
        if (cur_v < 480 && cur_h % 64 == 60 && cur_h < 576)
            e_addr = FB_BASE + 16'((cur_v / 4) * 10 + cur_h / 64 + 1);
        else if (cur_h == 796 && (cur_v == 524 || cur_v < 479))
            e_addr = FB_BASE + 16'((((cur_v + 1) % 525) / 4) * 10);
        if (mh == 799) begin
            mh = 0;
            if (mv == 524) begin
                mv = 0;
                first_frame = 1'b0;
            end else begin
                mv = mv + 1;
            end
        end else begin
            mh = mh + 1;
        end
    endtask

    task automatic release_reset();
        rst         = 1'b1;
        mpe         = 1'b0;
        mh          = 0;
        mv          = 0;
        first_frame = 1'b1;
        e_addr      = FB_BASE;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (addr_b !== FB_BASE) begin failures++; $display("FAIL reset_addr got=%h exp=%h", addr_b, FB_BASE); end
        checks++; if (vga_hs !== 1'b1) begin failures++; $display("FAIL reset_hs got=%b exp=1", vga_hs); end
        checks++; if (vga_vs !== 1'b1) begin failures++; $display("FAIL reset_vs got=%b exp=1", vga_vs); end
        checks++; if (vga_blank_n !== 1'b0) begin failures++; $display("FAIL reset_blank got=%b exp=0", vga_blank_n); end
        checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin failures++; $display("FAIL reset_rgb got=%h exp=0", {vga_r, vga_g, vga_b}); end
        checks++; if (vga_clk !== 1'b0) begin failures++; $display("FAIL reset_vga_clk got=%b exp=0", vga_clk); end
        checks++; if (we_b !== 1'b0 || vga_sync_n !== 1'b0) begin failures++; $display("FAIL reset_consts we_b=%b sync_n=%b exp=0,0", we_b, vga_sync_n); end
        release_reset();
    endtask

    // Line 0 of the first frame: word 0 was never prefetched, so h 0..63 show BG.
    task automatic test_first_line();
        logic [23:0] d;
        for (int i = 0; i < 800; i++) begin
            tick();
            checks++; if ({vga_r, vga_g, vga_b} !== e_rgb) begin failures++; $display("FAIL first_line_rgb h=%0d got=%h exp=%h", cur_h, {vga_r, vga_g, vga_b}, e_rgb); end
            checks++; if (addr_b !== e_addr) begin failures++; $display("FAIL first_line_addr h=%0d got=%h exp=%h", cur_h, addr_b, e_addr); end
            checks++; if (vga_clk !== 1'b0 || half_clk !== 1'b1) begin failures++; $display("FAIL vga_clk_phase h=%0d got=%b/%b exp=0/1", cur_h, vga_clk, half_clk); end
            if (cur_h < 64) begin
                d = BG_RGB;
`ifdef VGA_BORDER_EN
                d = FG_RGB;
`endif
                checks++; if ({vga_r, vga_g, vga_b} !== d) begin failures++; $display("FAIL first_word_bg h=%0d got=%h exp=%h", cur_h, {vga_r, vga_g, vga_b}, d); end
            end
        end
    endtask

    // Lines 1..4: word FB_BASE=8001 gives FG at h 0..3 and 60..63 on row 0.
    task automatic test_pixel_data();
        logic [23:0] d;
        for (int i = 0; i < 4 * 800; i++) begin
            tick();
            checks++; if ({vga_r, vga_g, vga_b} !== e_rgb) begin failures++; $display("FAIL pixel_rgb h=%0d v=%0d got=%h exp=%h", cur_h, cur_v, {vga_r, vga_g, vga_b}, e_rgb); end
            checks++; if (vga_blank_n !== e_blank) begin failures++; $display("FAIL pixel_blank h=%0d v=%0d got=%b exp=%b", cur_h, cur_v, vga_blank_n, e_blank); end
            checks++; if (addr_b !== e_addr) begin failures++; $display("FAIL pixel_addr h=%0d v=%0d got=%h exp=%h", cur_h, cur_v, addr_b, e_addr); end
            if (cur_v < 4 && cur_h < 64) begin
                d = (cur_h < 4 || cur_h >= 60) ? FG_RGB : BG_RGB;
                checks++; if ({vga_r, vga_g, vga_b} !== d) begin failures++; $display("FAIL word8001 h=%0d v=%0d got=%h exp=%h", cur_h, cur_v, {vga_r, vga_g, vga_b}, d); end
            end
        end
    endtask

    // Line 5 (row 1): mid-line fetches FB_BASE+11..19, end-of-line fetch FB_BASE+10.
    task automatic test_address_sequence();
        logic [15:0] d;
        for (int i = 0; i < 800; i++) begin
            tick();
            checks++; if (addr_b !== e_addr) begin failures++; $display("FAIL addr_model h=%0d got=%h exp=%h", cur_h, addr_b, e_addr); end
            checks++; if ({vga_r, vga_g, vga_b} !== e_rgb) begin failures++; $display("FAIL addr_line_rgb h=%0d got=%h exp=%h", cur_h, {vga_r, vga_g, vga_b}, e_rgb); end
            if (cur_h % 64 == 60 && cur_h < 576) begin
                d = FB_BASE + 16'(11 + cur_h / 64);
                checks++; if (addr_b !== d) begin failures++; $display("FAIL addr_seq h=%0d got=%h exp=%h", cur_h, addr_b, d); end
            end
            if (cur_h == 796) begin
                checks++; if (addr_b !== FB_BASE + 16'd10) begin failures++; $display("FAIL addr_eol got=%h exp=%h", addr_b, FB_BASE + 16'd10); end
            end
        end
    endtask

    // Lines 6..19: full per-tick comparison plus per-line sync/blank widths.
    task automatic test_sync_counts();
        int hs_low, blank_hi;
        for (int ln = 6; ln < 20; ln++) begin
            hs_low   = 0;
            blank_hi = 0;
            for (int i = 0; i < 800; i++) begin
                tick();
                if (vga_hs === 1'b0) hs_low++;
                if (vga_blank_n === 1'b1) blank_hi++;
                checks++; if (vga_hs !== e_hs) begin failures++; $display("FAIL sync_hs h=%0d v=%0d got=%b exp=%b", cur_h, cur_v, vga_hs, e_hs); end
                checks++; if (vga_vs !== e_vs) begin failures++; $display("FAIL sync_vs h=%0d v=%0d got=%b exp=%b", cur_h, cur_v, vga_vs, e_vs); end
                checks++; if (vga_blank_n !== e_blank) begin failures++; $display("FAIL sync_blank h=%0d v=%0d got=%b exp=%b", cur_h, cur_v, vga_blank_n, e_blank); end
                checks++; if ({vga_r, vga_g, vga_b} !== e_rgb) begin failures++; $display("FAIL sync_rgb h=%0d v=%0d got=%h exp=%h", cur_h, cur_v, {vga_r, vga_g, vga_b}, e_rgb); end
                checks++; if (addr_b !== e_addr || we_b !== 1'b0) begin failures++; $display("FAIL sync_port h=%0d v=%0d addr=%h we=%b exp=%h,0", cur_h, cur_v, addr_b, we_b, e_addr); end
            end
            checks++; if (hs_low != 96) begin failures++; $display("FAIL hs_width v=%0d got=%0d exp=96", ln, hs_low); end
            checks++; if (blank_hi != 640) begin failures++; $display("FAIL blank_width v=%0d got=%0d exp=640", ln, blank_hi); end
        end
    endtask

    // Reset asserted mid-line for 3 clks while the counters sit at v=20, h=300.
    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (!(cur_h == 299 && cur_v == 20) && guard < 2000) begin
            tick();
            guard++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (we_b !== 1'b0) begin failures++; $display("FAIL mid_reset_we got=%b exp=0", we_b); end
        end
        checks++; if (addr_b !== FB_BASE) begin failures++; $display("FAIL mid_reset_addr got=%h exp=%h", addr_b, FB_BASE); end
        checks++; if (vga_hs !== 1'b1 || vga_vs !== 1'b1) begin failures++; $display("FAIL mid_reset_sync got=%b%b exp=11", vga_hs, vga_vs); end
        checks++; if (vga_blank_n !== 1'b0) begin failures++; $display("FAIL mid_reset_blank got=%b exp=0", vga_blank_n); end
        checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin failures++; $display("FAIL mid_reset_rgb got=%h exp=0", {vga_r, vga_g, vga_b}); end
        checks++; if (vga_clk !== 1'b0) begin failures++; $display("FAIL mid_reset_vga_clk got=%b exp=0", vga_clk); end
        release_reset();
    endtask

    // After release the raster restarts at 0,0 with no prefetched word 0.
    task automatic test_restart();
        for (int i = 0; i < 3 * 800; i++) begin
            tick();
            checks++; if ({vga_r, vga_g, vga_b} !== e_rgb) begin failures++; $display("FAIL restart_rgb h=%0d v=%0d got=%h exp=%h", cur_h, cur_v, {vga_r, vga_g, vga_b}, e_rgb); end
            checks++; if (vga_hs !== e_hs || vga_blank_n !== e_blank) begin failures++; $display("FAIL restart_timing h=%0d v=%0d got=%b%b exp=%b%b", cur_h, cur_v, vga_hs, vga_blank_n, e_hs, e_blank); end
            checks++; if (addr_b !== e_addr || we_b !== 1'b0) begin failures++; $display("FAIL restart_port h=%0d v=%0d addr=%h we=%b exp=%h,0", cur_h, cur_v, addr_b, we_b, e_addr); end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        for (int i = 0; i < 1200; i++) mem[FB_BASE + 16'(i)] = 16'($urandom);
        mem[FB_BASE]              = 16'h8001;
        mem[FB_BASE + 16'd1199]   = 16'hFFFF;
        test_reset();
        test_first_line();
        test_pixel_data();
        test_address_sequence();
        test_sync_counts();
        test_reset_mid();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
